// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/DM unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_MODE_W = 3;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef enum logic {OWN_IF, OWN_DM} owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (IF/DM) and memory-side signals for mem_arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arbiter_pkg::*;

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [MEM_MODE_W-1:0] dm_mode;
  logic                  dm_ack;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [MEM_MODE_W-1:0] mem_mode;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  err;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_mode,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
    output err
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_mode,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
    input  err
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait-state counter for a BUSY transaction; expired flags the cycle in
// which the count has reached TIMEOUT. Used only with MEM_ARBITER_TIMEOUT_EN.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Count BUSY cycles, restarting whenever a new transaction is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// IF/DM arbiter for a single-ported unified memory. DM has priority; after
// STARVE_LIMIT consecutive DM grants with IF waiting, IF is granted.
// Optional macro MEM_ARBITER_TIMEOUT_EN adds a wait-state timeout with err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  state_e                state, state_nx;
  owner_e                owner;
  logic [SC_W-1:0]       starve_cnt;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [MEM_MODE_W-1:0] mem_mode_q;
  logic [DATA_W-1:0]     if_rdata_q;
  logic [DATA_W-1:0]     dm_rdata_q;
  logic [DATA_W-1:0]     resp_data;
  logic                  grant, grant_dm, done, timed_out;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic err_q;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .run     (state == BUSY),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Arbitration in IDLE, completion detect in BUSY, single-cycle RESP
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant    = 1'b1;
          grant_dm = bus.dm_req && !(bus.if_req && starve_cnt == SC_MAX);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready || timed_out) begin
          done     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stores and timed-out transactions return zero data
  assign resp_data = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;

  // Request capture, response data and starvation tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      starve_cnt  <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      if (grant) begin
        owner       <= grant_dm ? OWN_DM : OWN_IF;
        mem_we_q    <= grant_dm && bus.dm_we;
        mem_addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
        mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
        mem_mode_q  <= grant_dm ? bus.dm_mode : '0;
        if (grant_dm && bus.if_req) begin
          if (starve_cnt != SC_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end else begin
          starve_cnt <= '0;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        err_q <= 1'b0;
`endif
      end
      if (done) begin
        if (owner == OWN_DM) begin
          dm_rdata_q <= resp_data;
        end else begin
          if_rdata_q <= resp_data;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        err_q <= !bus.mem_ready;
`endif
      end
    end
  end

  assign bus.mem_req   = (state == BUSY);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_mode  = mem_mode_q;
  assign bus.if_ack    = (state == RESP) && (owner == OWN_IF);
  assign bus.dm_ack    = (state == RESP) && (owner == OWN_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
  assign bus.err       = (state == RESP) && err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all checked by a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // memory responder configuration (wait_mode < 0: random 0..3 waits)
  int wait_mode = 0;
  bit noise     = 1'b0;
  int busy_k    = 0;
  int cur_wait  = 0;

  // reference model: free_in == 0 means the next edge is an arbitration point,
  // free_in < 0 means a transaction is outstanding
  int          free_in = 0;
  int          streak  = 0;
  bit          g_dm    = 1'b0;
  logic        g_we    = 1'b0;
  logic [31:0] g_addr  = '0;
  logic [31:0] g_wdata = '0;
  logic [2:0]  g_mode  = '0;
  int          grant_tag, ack_tag;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_reset();
    free_in = 0;
    streak  = 0;
    busy_k  = 0;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_mode   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // One clock: drive memory response, snapshot requests, advance, check.
  task automatic tick();
    bit          rdy, want_ack, want_err, samp;
    logic        s_if, s_dm, s_dm_we;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata, want_rdata;
    logic [2:0]  s_dm_mode;
    rdy      = 1'b0;
    want_ack = 1'b0;
    want_err = 1'b0;
    if (bus.mem_req === 1'b1) begin
      if (busy_k == 0) cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      rdy      = (busy_k == cur_wait);
      want_ack = rdy;
`ifdef MEM_ARBITER_TIMEOUT_EN
      if (!rdy && busy_k == TO) begin
        want_ack = 1'b1;
        want_err = 1'b1;
      end
`endif
      busy_k++;
    end else begin
      busy_k = 0;
      rdy    = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    bus.mem_ready = rdy;
    bus.mem_rdata = mem_word(bus.mem_addr);
    want_rdata    = (want_err || g_we) ? 32'h0 : mem_word(g_addr);

    samp       = (free_in == 0);
    s_if       = bus.if_req;
    s_if_addr  = bus.if_addr;
    s_dm       = bus.dm_req;
    s_dm_we    = bus.dm_we;
    s_dm_addr  = bus.dm_addr;
    s_dm_wdata = bus.dm_wdata;
    s_dm_mode  = bus.dm_mode;

    @(posedge clk);
    #1;
    cyc++;
    grant_tag = 0;
    ack_tag   = 0;

    if (samp) begin
      if (s_if || s_dm) begin
        g_dm    = s_dm && !(s_if && streak == LIMIT);
        streak  = (g_dm && s_if) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        g_we    = g_dm ? s_dm_we : 1'b0;
        g_addr  = g_dm ? s_dm_addr : s_if_addr;
        g_wdata = g_dm ? s_dm_wdata : 32'h0;
        g_mode  = g_dm ? s_dm_mode : 3'h0;
        grant_tag = g_dm ? 2 : 1;
        free_in   = -1;
        chk("grant_req", 32'(bus.mem_req), 32'd1);
      end else begin
        chk("idle_req", 32'(bus.mem_req), 32'd0);
      end
    end else if (free_in < 0) begin
      if (want_ack) begin
        chk("ack_if", 32'(bus.if_ack), 32'(!g_dm));
        chk("ack_dm", 32'(bus.dm_ack), 32'(g_dm));
        chk("rdata", g_dm ? bus.dm_rdata : bus.if_rdata, want_rdata);
        chk("ack_req", 32'(bus.mem_req), 32'd0);
        ack_tag = g_dm ? 2 : 1;
        free_in = 2;
      end else begin
        chk("busy_req", 32'(bus.mem_req), 32'd1);
      end
    end else begin
      chk("gap_req", 32'(bus.mem_req), 32'd0);
    end

    if (ack_tag == 0) chk("no_ack", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("err", 32'(bus.err), 32'(want_err && ack_tag != 0));
    if (free_in < 0) begin
      chk("mem_we", 32'(bus.mem_we), 32'(g_we));
      chk("mem_addr", bus.mem_addr, g_addr);
      chk("mem_wdata", bus.mem_wdata, g_wdata);
      chk("mem_mode", 32'(bus.mem_mode), 32'(g_mode));
    end
    if (free_in > 0) free_in--;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, ndm, acks;
    bit  if_won, if_pend, dm_pend;

    // reset state
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    rst = 1'b1;

    // IF only, zero wait
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    tick();
    chk("A_req", 32'(bus.mem_req), 32'd1);
    chk("A_addr", bus.mem_addr, 32'h10);
    tick();
    chk("A_if_ack", 32'(bus.if_ack), 32'd1);
    chk("A_if_rdata", bus.if_rdata, 32'h0010_0093);
    chk("A_dm_ack", 32'(bus.dm_ack), 32'd0);
    bus.if_req = 1'b0;
    tick();
    tick();

    // simultaneous IF and DM store: DM first, IF next
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0020;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_mode  = 3'b010;
    tick();
    chk("B_we", 32'(bus.mem_we), 32'd1);
    chk("B_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("B_addr", bus.mem_addr, 32'h100);
    tick();
    chk("B_dm_ack", 32'(bus.dm_ack), 32'd1);
    chk("B_dm_rdata", bus.dm_rdata, 32'd0);
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    tick();
    tick();
    chk("B_if_grant", 32'(grant_tag), 32'd1);
    chk("B_if_addr", bus.mem_addr, 32'h20);
    tick();
    chk("B_if_ack", 32'(bus.if_ack), 32'd1);
    bus.if_req = 1'b0;
    tick();

    // starvation guard: DM held continuously with IF pending
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0200;
    ndm    = 0;
    if_won = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant_tag == 2 && !if_won) begin
        ndm++;
        if (ndm == LIMIT) chk("C_starve_full", 32'(dut.starve_cnt), 32'(LIMIT));
      end
      if (grant_tag == 1) begin
        if_won = 1'b1;
        chk("C_starve_clr", 32'(dut.starve_cnt), 32'd0);
      end
      if (ack_tag == 2) bus.dm_addr = bus.dm_addr + 32'd4;
      if (ack_tag == 1) break;
    end
    chk("C_dm_grants", 32'(ndm), 32'(LIMIT));
    chk("C_if_won", 32'(if_won), 32'd1);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
    tick();

    // load with three wait states
    wait_mode   = 3;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0300;
    bus.dm_mode = 3'b100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (ack_tag == 2) break;
    end
    chk("D_latency", 32'(n), 32'd5);
    bus.dm_req = 1'b0;
    wait_mode  = 0;
    tick();
    tick();

    // reset asserted during BUSY
    wait_mode   = 100000;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0050;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("E_req", 32'(bus.mem_req), 32'd0);
    chk("E_acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("E_err", 32'(bus.err), 32'd0);
    chk("E_addr", bus.mem_addr, 32'd0);
    bus.if_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    wait_mode = 0;
    repeat (3) tick();
    chk("E_state", 32'(dut.state), 32'(IDLE));

    // memory never ready
    wait_mode   = 100000;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0060;
`ifdef MEM_ARBITER_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (ack_tag != 0) break;
    end
    chk("F_latency", 32'(n), 32'(TO + 2));
    chk("F_err", 32'(bus.err), 32'd1);
    chk("F_rdata", bus.dm_rdata, 32'd0);
    bus.dm_req = 1'b0;
    wait_mode  = 0;
    tick();
    tick();
`else
    acks = 0;
    repeat (1000) begin
      tick();
      if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) acks++;
    end
    chk("F_no_ack", 32'(acks), 32'd0);
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    wait_mode = 0;
    tick();
`endif

    // randomized traffic with random wait states and stray mem_ready
    wait_mode = -1;
    noise     = 1'b1;
    if_pend   = 1'b0;
    dm_pend   = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!if_pend && $urandom_range(0, 99) < 40) begin
        if_pend     = 1'b1;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(0, 99) < 70) begin
        dm_pend      = 1'b1;
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_mode  = 3'($urandom_range(0, 7));
      end
      bus.if_req = if_pend;
      bus.dm_req = dm_pend;
      tick();
      if (ack_tag == 1) if_pend = 1'b0;
      if (ack_tag == 2) dm_pend = 1'b0;
    end
    for (int i = 0; i < 60 && (if_pend || dm_pend); i++) begin
      bus.if_req = if_pend;
      bus.dm_req = dm_pend;
      tick();
      if (ack_tag == 1) if_pend = 1'b0;
      if (ack_tag == 2) dm_pend = 1'b0;
    end
    chk("G_drain", 32'({if_pend, dm_pend}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
